btn_debounce_multi: RTL and testbench

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

---
 rtl/btn_debounce_multi.sv | 86 ++++++++
 tb/tb_btn_debounce_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: multi-channel button debouncer with press, release and long-press events
module btn_debounce_multi #(
    parameter int NUM_BTN    = 3,
    parameter int DIV        = 100000,
    parameter int DEPTH      = 8,
    parameter int LONG_TICKS = 200,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               clr,
    output logic [NUM_BTN-1:0] btn_out,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_press,
    output logic               tick
);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [15:0]   LONG_MAX = 16'(LONG_TICKS);

    logic [NUM_BTN-1:0] r_sync1, r_sync2, w_s;
    logic [CW-1:0]      r_cnt;

    // two-flop synchroniser for the raw, asynchronous button levels
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end

    assign w_s  = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign tick = (r_cnt == CNT_MAX);

    // free-running sample prescaler; clr deliberately leaves it alone
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) r_cnt <= '0;
        else       r_cnt <= tick ? '0 : r_cnt + CW'(1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DEPTH-1:0] r_hist, w_hist;
        logic [15:0]      r_hold;
        logic             r_out, r_press, r_rel, r_long, w_out;

        assign w_hist = {r_hist[DEPTH-2:0], w_s[i]};
        assign w_out  = &w_hist ? 1'b1 : ~|w_hist ? 1'b0 : r_out;

        // on each tick shift in a sample, update the level and raise one-cycle events
        always_ff @(posedge clk_sys or posedge reset)
            if (reset) begin
                r_hist  <= '0;
                r_hold  <= '0;
                r_out   <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
            end else if (clr) begin
                r_hist  <= '0;
                r_hold  <= '0;
                r_out   <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
            end else if (tick) begin
                r_hist  <= w_hist;
                r_out   <= w_out;
                r_press <= w_out & ~r_out;
                r_rel   <= ~w_out & r_out;
                r_long  <= w_out & r_out & (r_hold == LONG_MAX - 16'd1);
                r_hold  <= !w_out ? '0 : (r_out && r_hold != LONG_MAX) ? r_hold + 16'd1 : r_hold;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
            end

        assign btn_out[i]    = r_out;
        assign press[i]      = r_press;
        assign release_o[i]  = r_rel;
        assign long_press[i] = r_long;
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed table-driven check of the debouncer with short sample period
module tb_btn_debounce_multi;
    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       clr     = 1'b0;
    logic [2:0] btn_in  = 3'b110;
    logic [2:0] btn_out, press, release_o, long_press;
    logic       tick;
    int         total = 0;
    int         bad   = 0;
    logic [2:0] prev_out = 3'b000;

    typedef struct packed {
        logic [2:0] b;
        logic [2:0] o;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] l;
    } vec_t;

    vec_t vecs [23];

    btn_debounce_multi #(
        .NUM_BTN(3), .DIV(4), .DEPTH(3), .LONG_TICKS(5), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .btn_in(btn_in),
        .clr(clr),
        .btn_out(btn_out),
        .press(press),
        .release_o(release_o),
        .long_press(long_press),
        .tick(tick)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [12:0] obs();
        return {tick, btn_out, press, release_o, long_press};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got tick/out/press/rel/long=%b expected %b", name, act, exp);
        end
    endtask

    // called at the falling edge of the cycle just after a tick; spans one full sample period
    task automatic do_vec(input string name, input logic [2:0] b, input logic [2:0] o,
                          input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
        logic        ok;
        logic [12:0] g, e;
        ok = 1'b1;
        g  = '0;
        e  = '0;
        btn_in = b;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_sys);
            if (ok && obs() !== {k == 3, prev_out, 9'b0}) begin
                ok = 1'b0;
                g  = obs();
                e  = {k == 3, prev_out, 9'b0};
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_mid: got tick/out/press/rel/long=%b expected %b", name, g, e);
        end
        @(negedge clk_sys);
        check(name, obs(), {1'b0, o, p, r, l});
        prev_out = o;
    endtask

    initial begin
        vecs = '{
            '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b110, 3'b001, 3'b001, 3'b000, 3'b000},
            '{3'b101, 3'b001, 3'b000, 3'b000, 3'b000},
            '{3'b101, 3'b001, 3'b000, 3'b000, 3'b000},
            '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000},
            '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b100, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b100},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b011, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b111, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b111, 3'b100, 3'b000, 3'b000, 3'b000},
            '{3'b111, 3'b000, 3'b000, 3'b100, 3'b000},
            '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000},
            '{3'b000, 3'b111, 3'b111, 3'b000, 3'b000},
            '{3'b000, 3'b111, 3'b000, 3'b000, 3'b000}
        };
        repeat (3) @(negedge clk_sys);
        check("reset_state", obs(), 13'b0);
        reset = 1'b0;
        foreach (vecs[i])
            do_vec($sformatf("v%0d", i + 1), vecs[i].b, vecs[i].o, vecs[i].p, vecs[i].r, vecs[i].l);
        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0;
        prev_out = 3'b000;
        check("clr_cleared", obs(), 13'b0);
        @(negedge clk_sys);
        check("clr_cnt2", obs(), 13'b0);
        @(negedge clk_sys);
        check("clr_tick_cadence", obs(), {1'b1, 12'b0});
        @(negedge clk_sys);
        check("clr_after_t1", obs(), 13'b0);
        do_vec("clr_t2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        do_vec("clr_t3", 3'b000, 3'b111, 3'b111, 3'b000, 3'b000);
        do_vec("hold", 3'b000, 3'b111, 3'b000, 3'b000, 3'b000);
        reset = 1'b1;
        #1;
        check("rst_async", obs(), 13'b0);
        repeat (2) @(negedge clk_sys);
        check("rst_held", obs(), 13'b0);
        reset = 1'b0;
        prev_out = 3'b000;
        do_vec("rr_t1", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        do_vec("rr_t2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        do_vec("rr_t3", 3'b000, 3'b111, 3'b111, 3'b000, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
